pe_mac: RTL and testbench
=========================

# pe_mac

Signed multiply-accumulate processing element driven by the `counter_fsm` controller. It sits between the source buffer, which is read under `en_rd`/`addr_rd`, and the result buffer, which is written under `en_wr`/`addr_wr`. On each `en` (tied to `en_pe`) it consumes one operand pair through a 3-stage pipeline and accumulates the products. It presents the running sum, an overflow flag and a term count for the write stage.

## Interface
- `DATA_W`, 8: operand width, signed two's complement.
- `ACC_W`, 20: accumulator width. Must be ≥ 2·`DATA_W`. The default holds 16 worst-case terms without saturating.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clr`  in  1  synchronous clear of pipeline and accumulator.
- `en`  in  1  operand pair valid this cycle (driven by `en_pe`).
- `last_in`  in  1  marks the final term of a sequence; qualified by `en`.
- `a_in`  in  `DATA_W`  signed operand A.
- `b_in`  in  `DATA_W`  signed operand B.
- `acc_out`  out  `ACC_W`  signed accumulator value.
- `valid_out`  out  1  one-cycle pulse: `acc_out` was just updated.
- `last_out`  out  1  `last_in` delayed to align with `valid_out`.
- `ovf`  out  1  sticky saturation flag.
- `count_out`  out  5  number of terms accumulated since the last clear; wraps 31→0.

## Operation
- **Stage 1 (S1):** when `en`=1, register `a_in`, `b_in` and `last_in`; `s1_v` <= `en`.
- **Stage 2 (S2):** register the full-precision signed product `a`·`b` (2·`DATA_W` bits); `s2_v` <= `s1_v`; `last` follows.
- **Stage 3 (S3), on `s2_v`=1:**
  - `acc` <= sat(`acc` + sign-extended product).
  - `count_out` increments.
  - `valid_out` pulses for one cycle; `last_out` = the S2 `last`.
- **Saturation:** a positive overflow clamps to 2^(`ACC_W`−1)−1 and a negative overflow clamps to −2^(`ACC_W`−1). Either case sets `ovf`=1. `ovf` stays set until `clr` or reset.
- **`clr`:** highest synchronous priority. It zeroes `acc`, `count_out` and `ovf`, and clears `s1_v` and `s2_v`, so in-flight terms are discarded. If `en` and `clr` are both high, the sample is dropped. `valid_out` and `last_out` are 0 in the cycle after `clr`.
- **Idle:** with `en`=0 no state changes except the valid bits shifting.
- Back-to-back `en` is supported at full rate, one term per cycle. There is no back-pressure.

## Timing
- **Reset (async assert, sync release by system):** all outputs 0 and all pipeline registers 0 while `rst_n`=0, including mid-stream. After release the block behaves as freshly cleared.
- **Latency:** a term presented in cycle c (with `en`=1) is reflected in `acc_out`/`count_out` in cycle c+3. `valid_out`=1 only in cycle c+3.
- **Alignment with the controller:** the controller must assert `en_wr` three cycles after `en_pe` for the last term, so that the write samples the final `acc_out` with `last_out`=1.
- **`clr` in cycle k:** outputs are cleared in cycle k+1. Terms with `en` in cycles k−2..k never reach `acc`.
- **`count_out`:** 5-bit modulo counter. The 32nd term wraps it to 0, while `acc` continues to accumulate.

## Structure
- **Shared package `pe_pkg`:** default `DATA_W` and `ACC_W`, plus the acc max/min constants expressed as functions of `ACC_W`. `counter_fsm` uses the same package for its 3-cycle PE latency constant `PE_LAT`=3.
- **Sub-module `pe_sat_add`:** combinational. Inputs are the `ACC_W` accumulator and the 2·`DATA_W` product. Outputs are the saturated sum and an overflow bit. The pipeline registers stay in `pe_mac`.

## Test plan
- **Reset:** hold `rst_n`=0 with `en`=1 and random operands → `acc_out`=0, `valid_out`=0, `ovf`=0, `count_out`=0 throughout. Release and pulse `clr` → outputs still 0.
- **Single term:** `clr`, then `en`=1, `a`=3, `b`=4, `last_in`=1 in cycle c → in cycle c+3, `acc_out`=12, `valid_out`=1, `last_out`=1, `count_out`=1. In cycle c+4, `valid_out`=0.
- **16-term stream:** `a`=i, `b`=−2 for i=0..15 on consecutive cycles, `last_in` on i=15 → `valid_out` high for 16 consecutive cycles. Final `acc_out`=−240, `count_out`=16, `last_out` on the 16th pulse, `ovf`=0.
- **Saturation (build with `ACC_W`=16):** `a`=`b`=−128 three times → `acc_out` goes 16384, 32767 (`ovf`=1), 32767. `ovf` stays 1 until `clr`.
- **Clear mid-stream:** terms 5·1, 5·1, 5·1 in cycles c..c+2, `clr` in cycle c+1 → `acc_out`=0 in cycle c+2. Only the c+2 term lands: `acc_out`=5 and `count_out`=1 in cycle c+5. Also cover `en`+`clr` in the same cycle → that term is dropped.
- **Async reset mid-stream:** drop `rst_n` in the middle of a 16-term stream → outputs go to 0 immediately, with no `valid_out` after release. A new sequence then produces correct sums.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE package: default widths, pipeline latency and accumulator limits.
package pe_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 20;
   localparam int PE_LAT     = 3;
   localparam int CNT_W      = 5;

   // Largest signed value an acc_w-bit accumulator can hold.
   function automatic longint acc_max(input int acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   // Most negative signed value an acc_w-bit accumulator can hold.
   function automatic longint acc_min(input int acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction
endpackage

// File: rtl/pe_mac_if.sv
// Operand/result bundle between the controller side and the MAC element.
interface pe_mac_if
   import pe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
);
   logic                     clr;
   logic                     en;
   logic                     last_in;
   logic signed [DATA_W-1:0] a_in;
   logic signed [DATA_W-1:0] b_in;
   logic signed [ACC_W-1:0]  acc_out;
   logic                     valid_out;
   logic                     last_out;
   logic                     ovf;
   logic [CNT_W-1:0]         count_out;

   modport master (
      output clr, en, last_in, a_in, b_in,
      input  acc_out, valid_out, last_out, ovf, count_out
   );

   modport slave (
      input  clr, en, last_in, a_in, b_in,
      output acc_out, valid_out, last_out, ovf, count_out
   );
endinterface

// File: rtl/pe_sat_add.sv
// Saturating signed add of a full-precision product into the accumulator.
module pe_sat_add
   import pe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic signed [ACC_W-1:0]    acc,
   input  logic signed [2*DATA_W-1:0] prod,
   output logic signed [ACC_W-1:0]    sum,
   output logic                       ovf
);
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

   // One guard bit is enough: the product never exceeds the accumulator range.
   logic signed [ACC_W:0] wide;

   // Add with a guard bit, then clamp toward the sign of the true result.
   always_comb begin
      wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
      ovf  = wide[ACC_W] ^ wide[ACC_W-1];
      sum  = wide[ACC_W-1:0];
      if (ovf) sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
   end
endmodule

// File: rtl/pe_mac.sv
// Three-stage signed multiply-accumulate element: capture, multiply, accumulate.
module pe_mac
   import pe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input logic       clk,
   input logic       rst_n,
   pe_mac_if.slave   bus
);
   // vld_pipe[0]=S1 valid, [1]=S2 valid, [2]=result just updated.
   logic [PE_LAT-1:0]          vld_pipe;
   logic signed [DATA_W-1:0]   s1_a, s1_b;
   logic                       s1_last;
   logic signed [2*DATA_W-1:0] s2_prod;
   logic                       s2_last;
   logic signed [ACC_W-1:0]    acc_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       ovf_q;
   logic                       last_q;
   logic signed [ACC_W-1:0]    sat_sum;
   logic                       sat_ovf;

   pe_sat_add #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_sat (
      .acc  (acc_q),
      .prod (s2_prod),
      .sum  (sat_sum),
      .ovf  (sat_ovf)
   );

   // Whole pipeline in one block; clr beats everything and drops in-flight terms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_last  <= 1'b0;
         s2_prod  <= '0;
         s2_last  <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         last_q   <= 1'b0;
      end else if (bus.clr) begin
         vld_pipe <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[PE_LAT-2:0], bus.en};
         if (bus.en) begin
            s1_a    <= bus.a_in;
            s1_b    <= bus.b_in;
            s1_last <= bus.last_in;
         end
         if (vld_pipe[0]) begin
            s2_prod <= s1_a * s1_b;
            s2_last <= s1_last;
         end
         last_q <= vld_pipe[1] & s2_last;
         if (vld_pipe[1]) begin
            acc_q <= sat_sum;
            cnt_q <= cnt_q + 1'b1;
            if (sat_ovf) ovf_q <= 1'b1;
         end
      end
   end

   assign bus.acc_out   = acc_q;
   assign bus.valid_out = vld_pipe[PE_LAT-1];
   assign bus.last_out  = last_q;
   assign bus.ovf       = ovf_q;
   assign bus.count_out = cnt_q;
endmodule

// File: tb/tb_pe_mac.sv
// Directed bench for pe_mac: scoreboard on the 20-bit build, saturation on a 16-bit build.
module tb_pe_mac;
   import pe_pkg::*;

   localparam longint MAX20 = (64'sd1 <<< 19) - 1;
   localparam longint MIN20 = -(64'sd1 <<< 19);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_mac_if #(.DATA_W(8), .ACC_W(20)) bus ();
   pe_mac_if #(.DATA_W(8), .ACC_W(16)) bus16 ();

   pe_mac #(.DATA_W(8), .ACC_W(20)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   pe_mac #(.DATA_W(8), .ACC_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   typedef struct {
      int     cyc;
      longint acc;
      int     cnt;
      logic   last;
      logic   ovf;
   } exp_t;

   exp_t   sb[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   longint m_acc = 0;
   int     m_cnt = 0;
   logic   m_ovf = 1'b0;

   // Cycle index; stimulus driven in cycle N is sampled at the edge that starts N+1.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard drain: each expected result must appear exactly in its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("missed_result_cycle", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("sb_valid", bus.valid_out, 1);
            chk("sb_acc", $signed(bus.acc_out), e.acc);
            chk("sb_count", bus.count_out, e.cnt);
            chk("sb_last", bus.last_out, e.last);
            chk("sb_ovf", bus.ovf, e.ovf);
         end else begin
            chk("spurious_valid", bus.valid_out, 0);
            chk("spurious_last", bus.last_out, 0);
         end
      end
   end

   // Drive one cycle on the 20-bit DUT; keep=0 marks a term the test expects to be discarded.
   task automatic step(input bit en, input int a, input int b, input bit last, input bit clr, input bit keep);
      @(posedge clk); #1;
      bus.en      = en;
      bus.a_in    = 8'(a);
      bus.b_in    = 8'(b);
      bus.last_in = last;
      bus.clr     = clr;
      if (clr) begin
         m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      end else if (en && keep) begin
         m_acc = m_acc + longint'(a) * longint'(b);
         if (m_acc > MAX20) begin m_acc = MAX20; m_ovf = 1'b1; end
         if (m_acc < MIN20) begin m_acc = MIN20; m_ovf = 1'b1; end
         m_cnt = (m_cnt + 1) % 32;
         sb.push_back('{cyc + 3, m_acc, m_cnt, last, m_ovf});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic step16(input bit en, input int a, input int b, input bit clr);
      @(posedge clk); #1;
      bus16.en = en; bus16.a_in = 8'(a); bus16.b_in = 8'(b);
      bus16.last_in = 1'b0; bus16.clr = clr;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.en = 0; bus.clr = 0; bus.last_in = 0; bus.a_in = 0; bus.b_in = 0;
      bus16.en = 0; bus16.clr = 0; bus16.last_in = 0; bus16.a_in = 0; bus16.b_in = 0;

      // Reset held with live random operands: everything stays zero.
      repeat (6) begin
         @(posedge clk); #1;
         bus.en = 1'b1; bus.last_in = 1'b1;
         bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
         #2;
         chk("rst_acc", $signed(bus.acc_out), 0);
         chk("rst_valid", bus.valid_out, 0);
         chk("rst_ovf", bus.ovf, 0);
         chk("rst_count", bus.count_out, 0);
      end
      bus.en = 1'b0; bus.last_in = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("post_clr_acc", $signed(bus.acc_out), 0);
      chk("post_clr_count", bus.count_out, 0);

      // Single term 3*4.
      step(1, 3, 4, 1, 0, 1);
      idle(5);
      chk("single_acc", $signed(bus.acc_out), 12);
      chk("single_count", bus.count_out, 1);

      // 16-term stream i*-2.
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(1, i, -2, i == 15, 0, 1);
      idle(5);
      chk("stream_acc", $signed(bus.acc_out), -240);
      chk("stream_count", bus.count_out, 16);
      chk("stream_ovf", bus.ovf, 0);

      // 32 terms: counter wraps, accumulator keeps going.
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 32; i++) step(1, 1, 1, i == 31, 0, 1);
      idle(5);
      chk("wrap_count", bus.count_out, 0);
      chk("wrap_acc", $signed(bus.acc_out), 32);

      // Clear mid-stream: first two terms dropped (second shares the clr cycle).
      step(1, 5, 1, 0, 0, 0);
      step(1, 5, 1, 0, 1, 0);
      step(1, 5, 1, 0, 0, 1);
      #1;
      chk("midclr_acc_zero", $signed(bus.acc_out), 0);
      chk("midclr_count_zero", bus.count_out, 0);
      idle(5);
      chk("midclr_acc", $signed(bus.acc_out), 5);
      chk("midclr_count", bus.count_out, 1);

      // en together with clr on its own: term dropped.
      step(1, 9, 9, 1, 1, 0);
      idle(5);
      chk("enclr_acc", $signed(bus.acc_out), 0);
      chk("enclr_count", bus.count_out, 0);

      // Positive saturation on the 16-bit build.
      step16(0, 0, 0, 1);
      step16(1, -128, -128, 0);
      step16(1, -128, -128, 0);
      step16(1, -128, -128, 0);
      step16(0, 0, 0, 0);
      chk("satp1_acc", $signed(bus16.acc_out), 16384);
      chk("satp1_valid", bus16.valid_out, 1);
      chk("satp1_ovf", bus16.ovf, 0);
      step16(0, 0, 0, 0);
      chk("satp2_acc", $signed(bus16.acc_out), 32767);
      chk("satp2_ovf", bus16.ovf, 1);
      step16(0, 0, 0, 0);
      chk("satp3_acc", $signed(bus16.acc_out), 32767);
      chk("satp3_count", bus16.count_out, 3);
      repeat (3) step16(0, 0, 0, 0);
      chk("satp_sticky_ovf", bus16.ovf, 1);
      chk("satp_idle_valid", bus16.valid_out, 0);
      step16(0, 0, 0, 1);
      step16(0, 0, 0, 0);
      chk("satp_clr_ovf", bus16.ovf, 0);
      chk("satp_clr_acc", $signed(bus16.acc_out), 0);

      // Negative saturation on the 16-bit build.
      step16(1, -128, 127, 0);
      step16(1, -128, 127, 0);
      step16(1, -128, 127, 0);
      step16(0, 0, 0, 0);
      chk("satn1_acc", $signed(bus16.acc_out), -16256);
      step16(0, 0, 0, 0);
      chk("satn2_acc", $signed(bus16.acc_out), -32512);
      chk("satn2_ovf", bus16.ovf, 0);
      step16(0, 0, 0, 0);
      chk("satn3_acc", $signed(bus16.acc_out), -32768);
      chk("satn3_ovf", bus16.ovf, 1);

      // Async reset in the middle of a stream.
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, i + 1, 3, 0, 0, 1);
      #2;
      rst_n = 1'b0;
      sb.delete();
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      #1;
      chk("arst_acc", $signed(bus.acc_out), 0);
      chk("arst_valid", bus.valid_out, 0);
      chk("arst_count", bus.count_out, 0);
      chk("arst_last", bus.last_out, 0);
      bus.en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      idle(4);
      for (int i = 0; i < 4; i++) step(1, 7, -3, i == 3, 0, 1);
      idle(5);
      chk("after_rst_acc", $signed(bus.acc_out), -84);
      chk("after_rst_count", bus.count_out, 4);

      idle(2);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
